pc16_jump: RTL

Sequential 16-bit program counter with an integrated jump-condition unit, feeding instruction addresses to the instruction memory of the 16-bit datapath. Each cycle it selects between hold, increment and jump-target. This is the 16-bit select-between-two-words function of the mux16 stage applied to a registered address. It also evaluates the 3-bit jump field against the ALU zero/negative flags, and detects the canonical "jump-to-self" halt idiom.

---
 rtl/pc16_jump.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pc16_jump.sv
// pc16_jump
// ---------
// 16-bit program counter with an integrated jump-condition unit. Each
// cycle the registered address either holds, increments (mod 2^16) or
// loads the jump target. The 3-bit jump field is evaluated against the
// ALU zero/negative flags. An unconditional jump to the current address
// is recognised as the halt idiom when HALT_DETECT is non-zero.
//
// Parameters:
//   RESET_VECTOR  address loaded into pc on reset
//   HALT_DETECT   1 = jump-to-self enters HALT, 0 = ordinary jump
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   stall     in   hold pc this cycle (beats jump and increment)
//   c_instr   in   compute instruction; qualifies jbits
//   jbits     in   {j1,j2,j3} = jump if negative / zero / positive
//   alu_zr    in   ALU result == 0
//   alu_ng    in   ALU result < 0
//   target    in   jump destination address
//   pc        out  current instruction address
//   pc_valid  out  pc holds a fetchable address
//   taken     out  pc was loaded from target at the last edge
//   halted    out  block is in HALT
module pc16_jump #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int          HALT_DETECT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        c_instr,
    input  logic [2:0]  jbits,
    input  logic        alu_zr,
    input  logic        alu_ng,
    input  logic [15:0] target,
    output logic [15:0] pc,
    output logic        pc_valid,
    output logic        taken,
    output logic        halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        pc_valid_q, pc_valid_d;
    logic        taken_q, taken_d;
    logic        halted_q, halted_d;
    logic        take;
    logic        self_jump;

    // Literal evaluation of the condition: the illegal zr=ng=1 flag state
    // gets no special treatment.
    assign take = c_instr & ((jbits[2] & alu_ng) |
                             (jbits[1] & alu_zr) |
                             (jbits[0] & ~alu_zr & ~alu_ng));

    // Only an unconditional jump to the current address is the halt idiom;
    // conditional self-jumps are ordinary taken jumps.
    assign self_jump = (HALT_DETECT != 0) && (jbits == 3'b111) && (target == pc_q);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (stall) begin
                    pc_d = pc_q;
                end else if (take) begin
                    pc_d    = target;
                    taken_d = 1'b1;
                    if (self_jump) begin
                        state_d = HALT;
                    end
                end else begin
                    pc_d = pc_q + 16'd1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
                pc_d    = RESET_VECTOR;
            end
        endcase
        // Status outputs are registered copies of the next state so that
        // no output depends combinationally on the state decode.
        pc_valid_d = (state_d != BOOT);
        halted_d   = (state_d == HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            taken_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            taken_q    <= taken_d;
            halted_q   <= halted_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = pc_valid_q;
    assign taken    = taken_q;
    assign halted   = halted_q;

endmodule
